uart_tx_gen2: RTL and testbench

Parametrised second-generation UART transmitter for the UART datapath. It replaces the FIFO-pop interface with a valid/ready handshake and supports configurable oversampling and 5..DATA_W data bits. It snapshots the frame configuration per character and adds a frame_done strobe. It sits between the TX FIFO and the pad, and is driven by the shared baud_tick generator.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_tx_gen2.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_gen2.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART datapath.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int MIN_DATA_W = 5;
    localparam int MAX_DATA_W = 9;

    // Limit a requested character length to MIN_DATA_W..max_len.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
        if (len < 4'(MIN_DATA_W)) return 4'(MIN_DATA_W);
        if (int'(len) > max_len) return 4'(max_len);
        return len;
    endfunction

    // Parity over the low len bits; stick parity forces the inverse of eps.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                        input logic [3:0] len,
                                        input logic eps,
                                        input logic stick);
        logic x;
        x = 1'b0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < int'(len)) x = x ^ data[i];
        end
        if (stick) return ~eps;
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops to settle metastability before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_tx_gen2.sv
// Second-generation UART transmitter: valid/ready input, per-character
// configuration snapshot, oversampled bit timing and a frame_done strobe.
// Optional macro UART_TX_CTS_EN adds a synchronized cts_n start gate.
//
// state  | meaning
// IDLE   | line high; waits for an accepted character (and cts when enabled)
// START  | start bit (0)
// DATA   | data bits, LSB first, clamped length
// PARITY | parity bit (only when the snapshot has pen=1)
// STOP   | stop period of 1, 1.5 or 2 bit times
module uart_tx_gen2
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_pen,
    input  logic              cfg_eps,
    input  logic              cfg_stick,
    input  logic              cfg_stb,
    input  logic              set_break,
`ifdef UART_TX_CTS_EN
    input  logic              cts_n,
`endif
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] TICK_ONE      = TW'(1);
    localparam logic [TW-1:0] BIT_RELOAD    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_RELOAD = TW'(OVERSAMPLE * 3 / 2 - 1);
    localparam logic [TW-1:0] STOP2_RELOAD  = TW'(2 * OVERSAMPLE - 1);

    tx_state_t           state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [3:0]          len_q, len_d;
    logic                pen_q, pen_d;
    logic                stb_q, stb_d;
    logic                par_q, par_d;
    logic                pending_q, pending_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tx_q, tx_d;

    logic [MAX_DATA_W-1:0] data_ext;
    logic [3:0]            in_len_c;
    logic [TW-1:0]         stop_reload;
    logic                  tx_bit;
    logic                  start_ok;

`ifdef UART_TX_CTS_EN
    logic cts_n_sync;

    uart_sync2 #(.RST_VAL(1'b1)) u_cts_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cts_n),
        .q     (cts_n_sync)
    );

    assign start_ok = ~cts_n_sync;
`else
    assign start_ok = 1'b1;
`endif

    assign in_len_c = clamp_len(cfg_len, DATA_W);

    // Zero-extend the incoming character for the width-generic parity helper.
    always_comb begin
        data_ext = '0;
        data_ext[DATA_W-1:0] = in_data;
    end

    // Stop period length is taken from the snapshot, never from live cfg.
    always_comb begin
        if (!stb_q)                 stop_reload = BIT_RELOAD;
        else if (len_q == 4'd5)     stop_reload = STOP15_RELOAD;
        else                        stop_reload = STOP2_RELOAD;
    end

    // Line value implied by the current state, before the output flop.
    always_comb begin
        case (state_q)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shift_q[0];
            PARITY:  tx_bit = par_q;
            default: tx_bit = 1'b1;
        endcase
    end

    // Handshake capture plus bit-timing state machine; moves only on baud_tick.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        len_d      = len_q;
        pen_d      = pen_q;
        stb_d      = stb_q;
        par_d      = par_q;
        pending_d  = pending_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_d       = tx_bit & ~set_break;

        // in_ready is only high in IDLE with nothing pending, so this never
        // collides with the frame-timing updates below.
        if (in_valid && in_ready_q) begin
            shift_d    = in_data;
            len_d      = in_len_c;
            pen_d      = cfg_pen;
            stb_d      = cfg_stb;
            par_d      = parity_bit(data_ext, in_len_c, cfg_eps, cfg_stick);
            pending_d  = 1'b1;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
        end

        if (baud_tick) begin
            if (state_q == IDLE) begin
                if (pending_q && start_ok) begin
                    state_d   = START;
                    tick_d    = BIT_RELOAD;
                    pending_d = 1'b0;
                end
            end else if (tick_q != '0) begin
                tick_d = tick_q - TICK_ONE;
            end else begin
                case (state_q)
                    START: begin
                        state_d = DATA;
                        tick_d  = BIT_RELOAD;
                        bit_d   = 4'd0;
                    end
                    DATA: begin
                        shift_d = shift_q >> 1;
                        if (bit_q == len_q - 4'd1) begin
                            state_d = pen_q ? PARITY : STOP;
                            tick_d  = pen_q ? BIT_RELOAD : stop_reload;
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            tick_d = BIT_RELOAD;
                        end
                    end
                    PARITY: begin
                        state_d = STOP;
                        tick_d  = stop_reload;
                    end
                    STOP: begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // All state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= 4'd0;
            shift_q    <= '0;
            len_q      <= 4'd0;
            pen_q      <= 1'b0;
            stb_q      <= 1'b0;
            par_q      <= 1'b0;
            pending_q  <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            pen_q      <= pen_d;
            stb_q      <= stb_d;
            par_q      <= par_d;
            pending_q  <= pending_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Scoreboard bench for uart_tx_gen2: the driver queues the hand-derived frame
// description on acceptance, the monitor captures tx per clock between the
// start bit and frame_done and compares against the queued entry.
module tb_uart_tx_gen2;

    localparam int OS = 16;

    typedef struct {
        int         id;
        logic [8:0] data;
        int         len;
        int         par;    // -1: no parity bit, otherwise the bit value
        int         stop;   // stop period in ticks
        int         scale;  // clocks per baud_tick
        bit         wave;   // compare the waveform, not only the length
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] cfg_len = 4'd8;
    logic       cfg_pen = 1'b0;
    logic       cfg_eps = 1'b0;
    logic       cfg_stick = 1'b0;
    logic       cfg_stb = 1'b0;
    logic       set_break = 1'b0;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int   checks = 0;
    int   errors = 0;
    int   tick_div = 1;
    exp_t exp_q[$];

    uart_tx_gen2 #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cfg_len    (cfg_len),
        .cfg_pen    (cfg_pen),
        .cfg_eps    (cfg_eps),
        .cfg_stick  (cfg_stick),
        .cfg_stb    (cfg_stb),
        .set_break  (set_break),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin : baud_gen
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c = (c + 1 >= tick_div) ? 0 : c + 1;
            baud_tick = (c == 0);
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [8:0] data, input int len,
                                input int par, input int stop, input int scale = 1,
                                input bit wave = 1'b1);
        exp_t e;
        e.id = id; e.data = data; e.len = len; e.par = par;
        e.stop = stop; e.scale = scale; e.wave = wave;
        return e;
    endfunction

    function automatic int exp_len(input exp_t e);
        return e.scale * (OS * (1 + e.len + ((e.par >= 0) ? 1 : 0)) + e.stop);
    endfunction

    function automatic logic exp_bit(input exp_t e, input int idx);
        int b;
        b = idx / (OS * e.scale);
        if (b == 0) return 1'b0;
        if (b <= e.len) return e.data[b-1];
        if (e.par >= 0 && b == e.len + 1) return e.par[0];
        return 1'b1;
    endfunction

    initial begin : monitor
        logic cap[$];
        bit   capturing;
        exp_t e;
        int   bad;
        int   n;
        capturing = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                capturing = 1'b0;
                cap.delete();
            end else begin
                if (capturing || tx == 1'b0) begin
                    capturing = 1'b1;
                    cap.push_back(tx);
                end
                if (frame_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("frame%0d_len", e.id), cap.size(), exp_len(e));
                        if (e.wave) begin
                            bad = -1;
                            n = (cap.size() < exp_len(e)) ? cap.size() : exp_len(e);
                            for (int i = 0; i < n; i++) begin
                                if (bad < 0 && cap[i] !== exp_bit(e, i)) bad = i;
                            end
                            check($sformatf("frame%0d_first_bad_sample", e.id), bad, -1);
                        end
                        check($sformatf("frame%0d_ready_at_done", e.id), int'(in_ready), 1);
                        check($sformatf("frame%0d_busy_at_done", e.id), int'(busy), 0);
                    end
                    capturing = 1'b0;
                    cap.delete();
                end
                if (cap.size() > 5000) begin
                    check("frame_runaway", cap.size(), 0);
                    capturing = 1'b0;
                    cap.delete();
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [3:0] len, input logic pen,
                        input logic eps, input logic stick, input logic stb, input exp_t e);
        int n;
        n = 0;
        in_data = d; cfg_len = len; cfg_pen = pen; cfg_eps = eps;
        cfg_stick = stick; cfg_stb = stb; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        // Disturb the configuration: the frame in flight must not notice.
        in_data = ~d; cfg_len = 4'd6; cfg_pen = ~pen; cfg_eps = ~eps;
        cfg_stick = ~stick; cfg_stb = ~stb;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy || exp_q.size() != 0), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout", int'(tx), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #12;
        check("rst_tx", int'(tx), 1);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1, 0xA5
        send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 9'h0A5, 8, -1, 16));
        wait_idle();

        // length 7, two stop bits, 0x55 (four ones): even->0, odd->1, stick eps=1 ->0
        send(8'h55, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, mk(2, 9'h055, 7, 0, 32));
        wait_idle();
        send(8'h55, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, mk(3, 9'h055, 7, 1, 32));
        wait_idle();
        send(8'h55, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, mk(4, 9'h055, 7, 0, 32));
        wait_idle();

        // length 5 with stb=1 -> 1.5 stop bits (24 ticks)
        send(8'h1F, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, mk(5, 9'h01F, 5, -1, 24));
        wait_idle();

        // length clamping: 12 -> 8, 2 -> 5
        send(8'h3C, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, mk(6, 9'h03C, 8, -1, 16));
        wait_idle();
        send(8'hE6, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, mk(7, 9'h0E6, 5, -1, 16));
        wait_idle();

        // back-to-back; pen goes 0->1 while frame 8 is in flight, frame 9 has parity
        send(8'h96, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, mk(8, 9'h096, 8, -1, 16));
        send(8'h96, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, mk(9, 9'h096, 8, 0, 16));
        wait_idle();

        // baud_tick every second clock: transitions only on ticks
        tick_div = 2;
        send(8'hC3, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, mk(10, 9'h0C3, 8, -1, 16, 2));
        wait_idle();
        tick_div = 1;
        repeat (3) @(posedge clk);
        #1;

        // break inside data of an all-ones character; frame timing unchanged
        send(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, mk(11, 9'h0FF, 8, -1, 16, 1, 1'b0));
        wait_start();
        repeat (40) @(negedge clk);
        check("brk_pre_tx", int'(tx), 1);
        @(posedge clk);
        #1;
        set_break = 1'b1;
        @(negedge clk);
        check("brk_registered_lag", int'(tx), 1);
        @(negedge clk);
        check("brk_tx_low", int'(tx), 0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        set_break = 1'b0;
        wait_idle();

        // reset in the middle of data bit 1 of 0xA5 (a zero bit)
        send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, mk(12, 9'h0A5, 8, -1, 16));
        wait_start();
        repeat (40) @(negedge clk);
        check("rst_mid_pre_tx", int'(tx), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", int'(tx), 1);
        check("rst_mid_in_ready", int'(in_ready), 1);
        check("rst_mid_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // recovery frame: odd parity on 0x5A (four ones) -> 1
        send(8'h5A, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, mk(13, 9'h05A, 8, 1, 16));
        wait_idle();

        repeat (5) @(posedge clk);
        check("scoreboard_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
